field_max_scanner: RTL and testbench
====================================

Name: field_max_scanner

Overview:
- Sequential controller that finds the largest field in a packed word by scanning its fields one per cycle.
- Uses a two-selector field-compare datapath: selector A holds the current best index, selector B holds the candidate index.
- Start/busy/done handshake, so a host FSM can request a scan of a latched operand and then read back the maximum value and its index.

Parameters:
- N_FIELDS, 4, number of fields in the operand word; must be ≥ 2.
- FIELD_W, 2, width in bits of each field.
- IDX_W, $clog2(N_FIELDS), width of the field index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- X  input  N_FIELDS*FIELD_W  packed operand; field i is X[i*FIELD_W +: FIELD_W].
- busy  output  1  high while a scan is in progress (SCAN and DONE states).
- done  output  1  one-cycle pulse when the result is valid.
- max_val  output  FIELD_W  maximum field value.
- max_idx  output  IDX_W  index of the maximum field; on a tie, the lowest index wins.
- all_eq  output  1  high if every field equals max_val.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values: state=IDLE, busy=0, done=0, max_val=0, max_idx=0, all_eq=0, internal registers=0.
- All outputs are registered.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge T:
  - latch X into x_reg; later changes on X have no effect on the scan in progress.
  - best_idx=0, cand_idx=1, eq_acc=1.
  - go to SCAN.
- IDLE, start=0: stay in IDLE; outputs hold their last result.
- SCAN, each cycle:
  - compare field[cand_idx] with field[best_idx], unsigned.
  - if field[cand_idx] > field[best_idx], best_idx←cand_idx. The comparison is strict, so ties keep the lower index.
  - eq_acc←eq_acc & (field[cand_idx]==field[0]).
  - if cand_idx==N_FIELDS-1: go to DONE. Otherwise cand_idx←cand_idx+1.
- SCAN lasts exactly N_FIELDS-1 cycles.
- DONE (one cycle):
  - done=1; max_val/max_idx/all_eq are loaded from best_idx/eq_acc.
  - go to IDLE.
- Latency: done is high in cycle T+N_FIELDS, counted from the start edge (T+4 for the defaults).
- busy rises at T+1, is high through the DONE cycle, and falls when the FSM returns to IDLE.
- Result outputs change only when entering DONE. They hold until the next DONE or reset.
- start while busy=1 is ignored, with no queueing.
- start held high continuously gives back-to-back scans: a new scan is accepted in the IDLE cycle following DONE.
- Reset asserted mid-scan: immediate return to IDLE with all outputs zero; the partial result is discarded.
- cand_idx never exceeds N_FIELDS-1, so there is no wrap-around.

Decomposition:
- Shared package/include holds:
  - state encodings: ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2.
  - defaults: N_FIELDS, FIELD_W.
- One combinational sub-module, field_pair_cmp:
  - inputs: operand, sel_a, sel_b.
  - outputs: field_a, field_b, b_gt_a, eq.
- The controller instantiates field_pair_cmp once, with sel_a=best_idx and sel_b=cand_idx.

Test Plan:
- X=8'b10_01_11_00, start pulse → done at T+4, max_val=2'b11, max_idx=1, all_eq=0, busy high T+1..T+4.
- Tie, X=8'b11_00_11_01 → max_val=2'b11, max_idx=1 (lowest of indices 1 and 3), all_eq=0.
- All equal, X=8'hAA → max_val=2'b10, max_idx=0, all_eq=1.
- X=8'h00 → max_val=0, max_idx=0, all_eq=1.
- Operand isolation:
  - start with X=8'hC0, change X to 8'h03 at T+1 → max_val=2'b11, max_idx=3.
  - second start pulse at T+2 is ignored: exactly one done pulse.
- Reset and back-to-back:
  - rst asserted at T+2 → busy=0, done=0, outputs 0 immediately; next scan of X=8'b01_11_00_10 gives max_idx=2.
  - start held high → done pulses every 5 cycles.

Source files
------------

// File: rtl/field_max_scanner_pkg.sv
// field_max_scanner_pkg
//    Shared definitions for the field maximum scanner: controller state
//    encoding and the default operand geometry.
//    No ports (package only).
package field_max_scanner_pkg;

   localparam int DEF_N_FIELDS = 4;
   localparam int DEF_FIELD_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/field_max_scanner_field_pair_cmp.sv
// field_pair_cmp
//    Combinational two-selector field comparator. Extracts two fields from a
//    packed operand and compares them as unsigned values.
//    Ports:
//       operand  in   packed word, field i = operand[i*FIELD_W +: FIELD_W]
//       sel_a    in   index of the first field (current best)
//       sel_b    in   index of the second field (candidate)
//       field_a  out  value of field[sel_a]
//       field_b  out  value of field[sel_b]
//       b_gt_a   out  field_b > field_a (unsigned, strict)
//       eq       out  field_b == field_a
module field_pair_cmp
   import field_max_scanner_pkg::*;
#(
   parameter int N_FIELDS = DEF_N_FIELDS,
   parameter int FIELD_W  = DEF_FIELD_W,
   parameter int IDX_W    = $clog2(N_FIELDS)
) (
   input  logic [N_FIELDS*FIELD_W-1:0] operand,
   input  logic [IDX_W-1:0]            sel_a,
   input  logic [IDX_W-1:0]            sel_b,
   output logic [FIELD_W-1:0]          field_a,
   output logic [FIELD_W-1:0]          field_b,
   output logic                        b_gt_a,
   output logic                        eq
);

   always_comb begin
      field_a = operand[int'(sel_a)*FIELD_W +: FIELD_W];
      field_b = operand[int'(sel_b)*FIELD_W +: FIELD_W];
      b_gt_a  = (field_b > field_a);
      eq      = (field_b == field_a);
   end

endmodule

// File: rtl/field_max_scanner.sv
// field_max_scanner
//    Finds the largest field of a latched packed operand, one field per
//    cycle. Ties resolve to the lowest index.
//    Handshake: start is sampled only while idle; busy is high from the cycle
//    after the accepting edge through the done cycle; done pulses for one
//    cycle when max_val/max_idx/all_eq hold the new result. start while busy
//    is dropped, never queued.
//    Ports:
//       clk      in   rising-edge clock
//       rst      in   asynchronous active-high reset
//       start    in   scan request
//       X        in   packed operand, field i = X[i*FIELD_W +: FIELD_W]
//       busy     out  scan in progress
//       done     out  one-cycle result-valid pulse
//       max_val  out  maximum field value
//       max_idx  out  index of the maximum field (lowest on ties)
//       all_eq   out  every field equals max_val
module field_max_scanner
   import field_max_scanner_pkg::*;
#(
   parameter int N_FIELDS = DEF_N_FIELDS,
   parameter int FIELD_W  = DEF_FIELD_W,
   parameter int IDX_W    = $clog2(N_FIELDS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_FIELDS*FIELD_W-1:0] X,
   output logic                        busy,
   output logic                        done,
   output logic [FIELD_W-1:0]          max_val,
   output logic [IDX_W-1:0]            max_idx,
   output logic                        all_eq
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FIELDS - 1);

   state_t                      state;
   state_t                      state_next;
   logic [N_FIELDS*FIELD_W-1:0] x_reg;
   logic [IDX_W-1:0]            best_idx;
   logic [IDX_W-1:0]            cand_idx;
   logic                        eq_acc;

   logic [FIELD_W-1:0]          field_a;
   logic [FIELD_W-1:0]          field_b;
   logic                        b_gt_a;
   logic                        eq;
   logic                        accept;
   logic                        last;

   // eq compares the candidate with the current best rather than field 0.
   // While eq_acc is still 1 no strict win has happened, so best_idx is 0
   // and the two are identical; once eq_acc drops it stays 0 either way.
   field_pair_cmp #(
      .N_FIELDS (N_FIELDS),
      .FIELD_W  (FIELD_W),
      .IDX_W    (IDX_W)
   ) u_cmp (
      .operand (x_reg),
      .sel_a   (best_idx),
      .sel_b   (cand_idx),
      .field_a (field_a),
      .field_b (field_b),
      .b_gt_a  (b_gt_a),
      .eq      (eq)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = (cand_idx == LAST_IDX);
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (last) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg    <= '0;
         best_idx <= '0;
         cand_idx <= '0;
         eq_acc   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         max_val  <= '0;
         max_idx  <= '0;
         all_eq   <= 1'b0;
      end else begin
         busy <= (state_next != ST_IDLE);
         done <= (state_next == ST_DONE);
         if (accept) begin
            x_reg    <= X;
            best_idx <= '0;
            cand_idx <= IDX_W'(1);
            eq_acc   <= 1'b1;
         end else if (state == ST_SCAN) begin
            if (b_gt_a) best_idx <= cand_idx;
            eq_acc <= eq_acc & eq;
            if (!last) cand_idx <= cand_idx + IDX_W'(1);
            // The result registers take the final compare directly so they
            // are already valid in the cycle done is high.
            if (last) begin
               max_val <= b_gt_a ? field_b : field_a;
               max_idx <= b_gt_a ? cand_idx : best_idx;
               all_eq  <= eq_acc & eq;
            end
         end
      end
   end

endmodule

// File: tb/tb_field_max_scanner.sv
// tb_field_max_scanner
//    Self-checking bench for field_max_scanner with default geometry
//    (4 fields x 2 bits). Expected results come from a direct max search
//    over the operand fields and are queued at start time; a monitor pops
//    and compares them on each done pulse, including the done cycle number.
module tb_field_max_scanner;

   localparam int NF = 4;
   localparam int FW = 2;
   localparam int IW = 2;
   localparam int RW = FW + IW + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic [NF*FW-1:0] x;
   logic          busy;
   logic          done;
   logic [FW-1:0] max_val;
   logic [IW-1:0] max_idx;
   logic          all_eq;

   int checks;
   int errors;
   int cyc;
   int done_cnt;

   logic [RW-1:0] exp_q[$];
   int            cyc_q[$];

   field_max_scanner dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .X       (x),
      .busy    (busy),
      .done    (done),
      .max_val (max_val),
      .max_idx (max_idx),
      .all_eq  (all_eq)
   );

   // clock / reset / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model: plain search over the fields, strict > keeps lowest
   function automatic logic [RW-1:0] model(input logic [NF*FW-1:0] op);
      int bv, bi, f0, f;
      bit all;
      bv  = -1;
      bi  = 0;
      all = 1'b1;
      f0  = int'((op >> 0) & 8'h03);
      for (int i = 0; i < NF; i++) begin
         f = int'((op >> (i * FW)) & 8'h03);
         if (f > bv) begin
            bv = f;
            bi = i;
         end
         if (f != f0) all = 1'b0;
      end
      return {FW'(bv), IW'(bi), all};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending scan (t=%0t)", $time);
         end else begin
            logic [RW-1:0] e;
            int            ec;
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            check("result", {max_val, max_idx, all_eq}, e);
            check("done_cycle", cyc, ec);
            check("busy_in_done", busy, 1'b1);
         end
         done_cnt++;
      end
   end

   // driver tasks
   task automatic wait_done(input int target, input int budget);
      for (int k = 0; k < budget && done_cnt < target; k++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
      end
   endtask

   task automatic do_scan(input logic [NF*FW-1:0] xv, input logic [NF*FW-1:0] x_late,
                          input bit restart);
      int base;
      base = done_cnt;
      @(negedge clk);
      #1;
      x     = xv;
      start = 1'b1;
      exp_q.push_back(model(xv));
      cyc_q.push_back(cyc + 4);
      @(negedge clk);
      #1;
      start = 1'b0;
      x     = x_late;
      check("busy_t1", busy, 1'b1);
      @(negedge clk);
      #1;
      check("busy_t2", busy, 1'b1);
      if (restart) start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      check("busy_t3", busy, 1'b1);
      wait_done(base + 1, 20);
      @(negedge clk);
      #1;
      check("busy_after", busy, 1'b0);
      check("done_pulse", done, 1'b0);
   endtask

   task automatic back_to_back(input logic [NF*FW-1:0] xv, input int n);
      int base;
      base = done_cnt;
      @(negedge clk);
      #1;
      x     = xv;
      start = 1'b1;
      for (int j = 0; j < n; j++) begin
         exp_q.push_back(model(xv));
         cyc_q.push_back(cyc + 4 + 5 * j);
      end
      wait_done(base + n, 10 * n);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("b2b_idle", busy, 1'b0);
   endtask

   initial begin
      logic [RW-1:0] held;
      int            base;
      checks   = 0;
      errors   = 0;
      done_cnt = 0;
      rst      = 1'b1;
      start    = 1'b0;
      x        = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", {max_val, max_idx, all_eq}, '0);
      rst = 1'b0;

      // directed cases
      do_scan(8'b10_01_11_00, 8'h00, 1'b0);
      do_scan(8'b11_00_11_01, 8'h00, 1'b0);
      do_scan(8'hAA, 8'h55, 1'b0);
      do_scan(8'h00, 8'hFF, 1'b0);

      // operand isolation and ignored restart while busy
      base = done_cnt;
      do_scan(8'hC0, 8'h03, 1'b1);
      held = model(8'hC0);
      repeat (10) @(negedge clk);
      #1;
      check("one_done_only", done_cnt - base, 1);
      check("result_holds", {max_val, max_idx, all_eq}, held);

      // reset in the middle of a scan
      @(negedge clk);
      #1;
      x     = 8'h33;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_result", {max_val, max_idx, all_eq}, '0);
      exp_q.delete();
      cyc_q.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      do_scan(8'b01_11_00_10, 8'h00, 1'b0);

      // start held high
      back_to_back(8'b00_10_11_01, 4);

      // random scans
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_scan(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test expected finish");
      $fatal(1, "timeout");
   end

endmodule
